// File: rtl/led_pattern_gen.sv
// LED pattern sequencer (FILL/RUN/BOUNCE/BLINK) paced by a step prescaler; q, step and done are registered.
// Define LED_PATTERN_GEN_BOUNCE_EN to build BOUNCE; without it mode 2 runs as RUN and no bounce direction state exists.
module led_pattern_gen #(
  parameter int WIDTH = 8,
  parameter int DIV_W = 4
) (
  input  logic             clk,
  input  logic             rs,
  input  logic             pause,
  input  logic [1:0]       mode,
  input  logic             dir,
  input  logic [DIV_W-1:0] step_div,
  output logic [WIDTH-1:0] q,
  output logic             step,
  output logic             done
);

  typedef enum logic [1:0] {
    M_FILL   = 2'd0,
    M_RUN    = 2'd1,
    M_BOUNCE = 2'd2,
    M_BLINK  = 2'd3
  } mode_e;

  localparam logic [WIDTH-1:0] ONES = '1;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] TWO  = WIDTH'(2);
  localparam logic [WIDTH-1:0] MSB  = ONE << (WIDTH - 1);

  function automatic logic [WIDTH-1:0] rev_bits(input logic [WIDTH-1:0] x);
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH; i++) r[i] = x[WIDTH-1-i];
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] orient(input logic [WIDTH-1:0] x, input logic d);
    return d ? rev_bits(x) : x;
  endfunction

  function automatic mode_e eff_mode(input logic [1:0] m);
`ifdef LED_PATTERN_GEN_BOUNCE_EN
    return mode_e'(m);
`else
    return (m == 2'd2) ? M_RUN : mode_e'(m);
`endif
  endfunction

  function automatic logic [WIDTH-1:0] start_pat(input mode_e m);
    return (m == M_RUN || m == M_BOUNCE) ? ONE : '0;
  endfunction

  logic [DIV_W-1:0] cnt_q;
  mode_e            mode_q;
  logic             dir_q;
  logic [WIDTH-1:0] q_q;
  logic             step_q;
  logic             done_q;

  logic             tick;
  logic             last;
  logic [WIDTH-1:0] canon;
  logic [WIDTH-1:0] canon_d;

  assign tick  = !pause && (cnt_q >= step_div);
  // q holds the oriented pattern; undo the orientation to step the canonical one
  assign canon = orient(q_q, dir_q);

`ifdef LED_PATTERN_GEN_BOUNCE_EN
  logic up_q;
  logic up_d;
`endif

  always_comb begin
    last    = 1'b0;
    canon_d = canon;
`ifdef LED_PATTERN_GEN_BOUNCE_EN
    up_d    = up_q;
`endif
    case (mode_q)
      M_FILL: begin
        last = (canon == MSB);
        if (canon == ONES)                    canon_d = canon << 1;
        else if (canon == '0 || canon[0])     canon_d = (canon << 1) | ONE;
        else                                  canon_d = canon << 1;
      end
`ifdef LED_PATTERN_GEN_BOUNCE_EN
      M_BOUNCE: begin
        // at WIDTH=2 the top position is also the turnaround, so 02 is last while still moving up
        last = (canon == TWO) && (!up_q || canon[WIDTH-1]);
        if (up_q && canon[WIDTH-1]) begin
          canon_d = canon >> 1;
          up_d    = 1'b0;
        end else if (up_q) begin
          canon_d = canon << 1;
        end else begin
          canon_d = canon >> 1;
        end
      end
`endif
      M_BLINK: begin
        last    = (canon == ONES);
        canon_d = ~canon;
      end
      default: begin
        last    = (canon == MSB);
        canon_d = canon << 1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rs) begin
      cnt_q  <= '0;
      step_q <= 1'b0;
      done_q <= 1'b0;
      mode_q <= eff_mode(mode);
      dir_q  <= dir;
      q_q    <= orient(start_pat(eff_mode(mode)), dir);
    end else if (pause) begin
      step_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      step_q <= tick;
      done_q <= tick && last;
      if (tick) begin
        cnt_q <= '0;
        if (last) begin
          mode_q <= eff_mode(mode);
          dir_q  <= dir;
          q_q    <= orient(start_pat(eff_mode(mode)), dir);
        end else begin
          q_q    <= orient(canon_d, dir_q);
        end
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

`ifdef LED_PATTERN_GEN_BOUNCE_EN
  always_ff @(posedge clk) begin
    if (!rs)       up_q <= 1'b1;
    else if (tick) up_q <= last ? 1'b1 : up_d;
  end
`endif

  assign q    = q_q;
  assign step = step_q;
  assign done = done_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Bench for led_pattern_gen: sequence-table reference model checked every cycle, plus directed literal checkpoints and random stimulus.
module tb_led_pattern_gen;
  localparam int WIDTH = 8;
  localparam int DIV_W = 4;

  logic             clk = 1'b0;
  logic             rs = 1'b0;
  logic             pause = 1'b0;
  logic [1:0]       mode = 2'd0;
  logic             dir = 1'b0;
  logic [DIV_W-1:0] step_div = '0;
  logic [WIDTH-1:0] q;
  logic             step;
  logic             done;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  led_pattern_gen #(.WIDTH(WIDTH), .DIV_W(DIV_W)) dut (
    .clk(clk), .rs(rs), .pause(pause), .mode(mode), .dir(dir),
    .step_div(step_div), .q(q), .step(step), .done(done)
  );

  function automatic int norm_mode(int m);
`ifdef LED_PATTERN_GEN_BOUNCE_EN
    return m;
`else
    return (m == 2) ? 1 : m;
`endif
  endfunction

  function automatic int plen(int m);
    case (norm_mode(m))
      0:       return 2 * WIDTH;
      1:       return WIDTH;
      2:       return 2 * WIDTH - 2;
      default: return 2;
    endcase
  endfunction

  // i-th state of the pattern period, written straight from the sequence tables
  function automatic logic [WIDTH-1:0] pval(int m, int i, bit d);
    logic [63:0] ones;
    logic [63:0] v;
    logic [WIDTH-1:0] c;
    logic [WIDTH-1:0] r;
    ones = (64'd1 << WIDTH) - 64'd1;
    case (norm_mode(m))
      0:       v = (i <= WIDTH) ? ((64'd1 << i) - 64'd1) : ((ones << (i - WIDTH)) & ones);
      1:       v = 64'd1 << i;
      2:       v = (i < WIDTH) ? (64'd1 << i) : (64'd1 << (2 * WIDTH - 2 - i));
      default: v = (i == 0) ? 64'd0 : ones;
    endcase
    c = v[WIDTH-1:0];
    for (int b = 0; b < WIDTH; b++) r[b] = c[WIDTH-1-b];
    return d ? r : c;
  endfunction

  int m_cnt = 0;
  int m_idx = 0;
  int m_mode = 0;
  bit m_dir = 1'b0;
  bit m_step = 1'b0;
  bit m_done = 1'b0;
  logic [WIDTH-1:0] exp_q;

  always @(posedge clk) begin
    if (!rs) begin
      m_cnt = 0; m_idx = 0; m_mode = int'(mode); m_dir = dir; m_step = 0; m_done = 0;
    end else if (pause) begin
      m_step = 0; m_done = 0;
    end else if (m_cnt >= int'(step_div)) begin
      m_cnt = 0; m_step = 1;
      if (m_idx == plen(m_mode) - 1) begin
        m_idx = 0; m_mode = int'(mode); m_dir = dir; m_done = 1;
      end else begin
        m_idx++; m_done = 0;
      end
    end else begin
      m_cnt++; m_step = 0; m_done = 0;
    end
    #1;
    exp_q = pval(m_mode, m_idx, m_dir);
    checks++;
    if (q !== exp_q || step !== m_step || done !== m_done) begin
      failures++;
      $display("FAIL model t=%0t q=%h step=%b done=%b required q=%h step=%b done=%b",
               $time, q, step, done, exp_q, m_step, m_done);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(input logic [1:0] m, input logic d, input logic [DIV_W-1:0] sd);
    rs = 1'b0; pause = 1'b0; mode = m; dir = d; step_div = sd;
    @(negedge clk);
    rs = 1'b1;
  endtask

  task automatic wait_q(input string name, input logic [WIDTH-1:0] val, input int bound);
    int k = 0;
    while (q !== val && k < bound) begin
      @(negedge clk);
      k++;
    end
    chk(name, 32'(q), 32'(val));
  endtask

  logic [WIDTH-1:0] fill_lit [16] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF,
                                      8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00};

  initial begin
    // FILL from reset, one step per cycle
    do_reset(2'd0, 1'b0, 4'd0);
    chk("reset_q", 32'(q), 32'h00);
    chk("reset_step", 32'(step), 32'h0);
    chk("reset_done", 32'(done), 32'h0);
    for (int i = 0; i < 16; i++) begin
      cyc(1);
      chk("fill_q", 32'(q), 32'(fill_lit[i]));
      chk("fill_done", 32'(done), (i == 15) ? 32'h1 : 32'h0);
    end

    // reversed RUN, step every third cycle
    do_reset(2'd1, 1'b1, 4'd2);
    chk("run_rev_start", 32'(q), 32'h80);
    cyc(2);
    chk("run_rev_hold", 32'(q), 32'h80);
    cyc(1);
    chk("run_rev_q", 32'(q), 32'h40);
    chk("run_rev_step", 32'(step), 32'h1);
    cyc(21);
    chk("run_rev_wrap", 32'(q), 32'h80);
    chk("run_rev_done", 32'(done), 32'h1);

    // pause mid-fill
    do_reset(2'd0, 1'b0, 4'd1);
    wait_q("pause_reach07", 8'h07, 40);
    pause = 1'b1;
    cyc(30);
    chk("pause_q", 32'(q), 32'h07);
    chk("pause_step", 32'(step), 32'h0);
    pause = 1'b0;
    cyc(1);
    chk("unpause_hold", 32'(q), 32'h07);
    cyc(1);
    chk("unpause_q", 32'(q), 32'h0F);
    chk("unpause_step", 32'(step), 32'h1);

    // mode change takes effect only after the period completes
    do_reset(2'd0, 1'b0, 4'd0);
    wait_q("mchg_reach1F", 8'h1F, 20);
    mode = 2'd3;
    wait_q("mchg_reach80", 8'h80, 20);
    cyc(1);
    chk("mchg_blink0", 32'(q), 32'h00);
    chk("mchg_done", 32'(done), 32'h1);
    cyc(1);
    chk("mchg_blinkFF", 32'(q), 32'hFF);
    chk("mchg_done2", 32'(done), 32'h0);

    // BOUNCE (or RUN when not built)
    do_reset(2'd2, 1'b0, 4'd0);
    chk("bounce_start", 32'(q), 32'h01);
    cyc(7);
    chk("bounce_top", 32'(q), 32'h80);
    cyc(1);
`ifdef LED_PATTERN_GEN_BOUNCE_EN
    chk("bounce_turn", 32'(q), 32'h40);
    cyc(6);
    chk("bounce_back", 32'(q), 32'h01);
    chk("bounce_done", 32'(done), 32'h1);
`else
    chk("bounce_as_run", 32'(q), 32'h01);
    chk("bounce_as_run_done", 32'(done), 32'h1);
    cyc(6);
    chk("bounce_as_run_q", 32'(q), 32'h40);
`endif

    // reset during pause
    do_reset(2'd0, 1'b0, 4'd0);
    wait_q("rstp_reach3F", 8'h3F, 20);
    pause = 1'b1;
    cyc(3);
    rs = 1'b0;
    mode = 2'd1;
    cyc(1);
    chk("rstp_q", 32'(q), 32'h01);
    chk("rstp_step", 32'(step), 32'h0);
    chk("rstp_done", 32'(done), 32'h0);
    rs = 1'b1;
    pause = 1'b0;

    // random stimulus, model checks every cycle
    for (int n = 0; n < 3000; n++) begin
      mode = 2'($urandom_range(0, 3));
      dir = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) step_div = 4'($urandom_range(0, 5));
      pause = ($urandom_range(0, 4) == 0);
      rs = ($urandom_range(0, 149) != 0);
      cyc(1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/led_pattern_gen.md
LED_PATTERN_GEN -- requirements
Module: led_pattern_gen

Interface
REQ-001 Parameter WIDTH, 8, number of LED outputs; legal range 2..32.
REQ-002 Parameter DIV_W, 4, width of the step-divider input.
REQ-003 Port clk  input  1  single clock; all logic on the rising edge.
REQ-004 Port rs  input  1  reset; synchronous, active-low.
REQ-005 Port pause  input  1  high freezes the block: prescaler, pattern and outputs hold.
REQ-006 Port mode  input  2  pattern select: 0 FILL, 1 RUN, 2 BOUNCE, 3 BLINK.
REQ-007 Port dir  input  1  0 = canonical pattern; 1 = bit-reversed pattern (bit i drives q[WIDTH-1-i]).
REQ-008 Port step_div  input  DIV_W  a pattern step occurs every step_div+1 unpaused cycles.
REQ-009 Port q  output  WIDTH  LED pattern, registered.
REQ-010 Port step  output  1  registered one-cycle pulse on every cycle in which q advances.
REQ-011 Port done  output  1  registered one-cycle pulse on the step that completes a pattern period.

Function
REQ-012 The prescaler counter SHALL clear to 0 and assert a tick when cnt >= step_div and pause=0; otherwise it SHALL increment when pause=0.
REQ-013 step_div=0 SHALL give one step per cycle; a step_div decrease below cnt SHALL tick on the next unpaused cycle.
REQ-014 Only ticks SHALL change q; step SHALL be high in the same cycle that q takes its new value.
REQ-015 With pause=1, cnt, q and the internal state SHALL hold, step and done SHALL be 0, and pause SHALL win over a coincident tick.
REQ-016 The canonical FILL sequence (WIDTH=8) SHALL be 00,01,03,…,FF,FE,FC,…,80; start 00; last 80; period 2*WIDTH.
REQ-017 The canonical RUN sequence SHALL be 01,02,…,80; start 01; last 80; period WIDTH.
REQ-018 The canonical BOUNCE sequence SHALL be 01,02,…,80,40,…,02; start 01; last 02; period 2*WIDTH-2.
REQ-019 The canonical BLINK sequence SHALL be 00,FF; start 00; last FF; period 2.
REQ-020 The mode and dir inputs SHALL be latched internally only at reset and on the period-completing step; changes at other times SHALL have no effect until that point.
REQ-021 On the step taken from the last state, q SHALL load the start state of the newly latched mode/dir, and done SHALL be high in that cycle.
REQ-022 q SHALL always equal the canonical state (dir_r=0) or its bit-reversal (dir_r=1); there SHALL be no combinational path from any input to q, step or done.

Reset
REQ-023 While rs=0 at a clock edge: cnt=0, step=0, done=0, and mode_r/dir_r SHALL load from the mode/dir inputs.
REQ-024 In the same reset cycle, q SHALL load the start state of that mode/dir, and the BOUNCE direction SHALL be set to upward.
REQ-025 Reset asserted mid-pattern or mid-pause SHALL take priority over pause and tick in the same cycle.

Configuration
REQ-026 Macro LED_PATTERN_GEN_BOUNCE_EN defined: BOUNCE SHALL be implemented per REQ-018.
REQ-027 LED_PATTERN_GEN_BOUNCE_EN undefined: mode=2 SHALL behave exactly as RUN, and no BOUNCE direction state SHALL be synthesised.

Verification
REQ-028 WIDTH=8, mode=0, dir=0, step_div=0, rs low for 1 cycle and then high -> q=00,01,03,…,FF,FE,…,80,00; done is high only on the return to 00 (16th step).
REQ-029 mode=1, dir=1, step_div=2 -> q=80,40,…,01,80, advancing every 3rd cycle; step pulses match; done fires on the wrap to 80.
REQ-030 mode=0 with pause=1 held 30 cycles mid-fill at q=07 -> q stays 07, step=0, done=0; after release, the next step gives 0F after step_div+1 cycles.
REQ-031 mode changed 0->3 while q=1F -> FILL completes to 80, then the next step gives q=00 with done=1, then FF,00,….
REQ-032 mode=2, step_div=0 -> 01,02,…,80,40,…,02,01 with done on each return to 01; with the macro undefined, the same stimulus -> the RUN sequence.
REQ-033 rs pulled low while q=3F and pause=1 -> the next cycle gives q equal to the start of the current mode input, cnt=0, step=0, done=0.
